// File: rtl/pcileech_fifo_pkg.sv
// Shared definitions for the PCILeech FT601 TX path: source indices, arbiter
// state encoding, stream magic and the TLP last-DWORD flag position.
package pcileech_fifo_pkg;

  localparam int unsigned NumSrc  = 4;
  localparam int unsigned SrcTlp  = 0;
  localparam int unsigned SrcCfg  = 1;
  localparam int unsigned SrcLoop = 2;
  localparam int unsigned SrcCmd  = 3;

  localparam logic [7:0]  Magic      = 8'h77;
  localparam int unsigned TlpLastBit = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StLock  = 2'd3
  } arb_state_e;

  // One-hot of the lowest set bit of v (zero when v is zero).
  function automatic logic [3:0] lowest_onehot(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/pcileech_starve_ctr.sv
// Saturating per-source starvation counter; flags a source that has lost
// arbitration for Limit consecutive cycles.
module pcileech_starve_ctr #(
  parameter int unsigned Limit = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic gnt_i,
  output logic starved_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q < CntW'(Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q >= CntW'(Limit));

endmodule

// File: rtl/pcileech_tx_arbiter.sv
// Four-source arbiter feeding the FT601 TX FIFO. TLP packets hold the sink
// until their last DWORD; CFG/LOOP/CMD sources move one word per grant.
module pcileech_tx_arbiter
  import pcileech_fifo_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 32,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [3:0]   src_empty,
  input  logic [3:0]   src_valid,
  input  logic [255:0] src_dout,
  output logic [3:0]   src_rden,
  input  logic [3:0]   src_enable,
  input  logic         sink_almost_full,
  output logic [63:0]  sink_din,
  output logic         sink_wren,
  output logic [3:0]   grant,
  output logic         err_timeout
);

  localparam int unsigned LockW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [LockW-1:0] idle_q, idle_d;

  logic [3:0] req;
  logic [3:0] starved;
  logic [3:0] starved_req;
  logic [3:0] win;
  logic       g_valid;
  logic       g_empty;
  logic       tlp_last;
  logic       timeout;

  assign req = src_enable & ~src_empty;

  for (genvar i = 0; i < NumSrc; i++) begin : g_starve
    pcileech_starve_ctr #(
      .Limit(STARVE_LIMIT)
    ) u_starve (
      .clk_i    (CLK),
      .rst_ni   (RESET_N),
      .req_i    (req[i]),
      .gnt_i    (grant_q[i]),
      .starved_o(starved[i])
    );
  end

  // Starved requesters pre-empt plain index priority.
  assign starved_req = starved & req;
  assign win         = lowest_onehot((|starved_req) ? starved_req : req);

  assign g_valid  = |(src_valid & grant_q);
  assign g_empty  = |(src_empty & grant_q);
  assign tlp_last = src_valid[SrcTlp] & src_dout[TlpLastBit];
  assign timeout  = (idle_q == LockW'(LOCK_TIMEOUT)) & ~src_valid[SrcTlp];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idle_d      = idle_q;
    src_rden    = '0;
    err_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        idle_d = '0;
        if (|req) begin
          grant_d = win;
          state_d = win[SrcTlp] ? StLock : StIssue;
        end
      end
      StIssue: begin
        if (!g_empty && !sink_almost_full) begin
          src_rden = grant_q;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        if (g_valid) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      StLock: begin
        if (timeout) begin
          err_timeout = 1'b1;
          grant_d     = '0;
          idle_d      = '0;
          state_d     = StIdle;
        end else begin
          // Stop fetching once the last DWORD is on the bus.
          src_rden[SrcTlp] = ~src_empty[SrcTlp] & ~sink_almost_full & ~tlp_last;
          idle_d = src_valid[SrcTlp] ? '0 : idle_q + 1'b1;
          if (tlp_last) begin
            grant_d = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      grant_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    sink_din = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (grant_q[i]) begin
        sink_din = src_dout[64*i +: 64];
      end
    end
  end

  assign sink_wren = g_valid;
  assign grant     = grant_q;

endmodule

// File: tb/tb_pcileech_tx_arbiter.sv
// Directed bench for pcileech_tx_arbiter: priority vector table plus
// hand-written packet, starvation, back-pressure, timeout and reset sequences.
module tb_pcileech_tx_arbiter;
  import pcileech_fifo_pkg::*;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic [3:0]   src_empty;
  logic [3:0]   src_valid;
  logic [255:0] src_dout;
  logic [3:0]   src_rden;
  logic [3:0]   src_enable;
  logic         sink_almost_full;
  logic [63:0]  sink_din;
  logic         sink_wren;
  logic [3:0]   grant;
  logic         err_timeout;

  always #5 CLK = ~CLK;

  pcileech_tx_arbiter #(
    .STARVE_LIMIT(4),
    .LOCK_TIMEOUT(16)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .src_empty       (src_empty),
    .src_valid       (src_valid),
    .src_dout        (src_dout),
    .src_rden        (src_rden),
    .src_enable      (src_enable),
    .sink_almost_full(sink_almost_full),
    .sink_din        (sink_din),
    .sink_wren       (sink_wren),
    .grant           (grant),
    .err_timeout     (err_timeout)
  );

  // Source FIFO model: data valid one cycle after read enable.
  logic [63:0] mem [4][32];
  logic [31:0] wr_ptr [4] = '{default: '0};
  logic [31:0] rd_ptr [4] = '{default: '0};
  logic [63:0] dout_r [4] = '{default: '0};
  logic [3:0]  valid_r = '0;
  logic [3:0]  flush;

  always @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (flush[i]) begin
        rd_ptr[i]  <= wr_ptr[i];
        valid_r[i] <= 1'b0;
      end else begin
        valid_r[i] <= src_rden[i];
        if (src_rden[i]) begin
          dout_r[i] <= mem[i][rd_ptr[i][4:0]];
          rd_ptr[i] <= rd_ptr[i] + 32'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_fifo
    assign src_empty[i]          = (wr_ptr[i] == rd_ptr[i]);
    assign src_valid[i]          = valid_r[i];
    assign src_dout[64*i +: 64]  = dout_r[i];
  end

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] load;
    logic [3:0] exp_grant;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_n, rd0_n, err_n;
  logic [63:0] wlog [$];
  int          wcyc [$];
  logic [3:0]  ghist [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int s, input int idx, input logic last);
    logic [63:0] w;
    w = {Magic, 8'(s), 16'h0, 16'(idx), 16'h0};
    w[TlpLastBit] = last;
    return w;
  endfunction

  task automatic push(input int s, input logic [63:0] w);
    mem[s][wr_ptr[s][4:0]] = w;
    wr_ptr[s] = wr_ptr[s] + 32'd1;
  endtask

  function automatic logic [63:0] wl(input int i);
    return (i < wlog.size()) ? wlog[i] : '1;
  endfunction

  function automatic int wc(input int i);
    return (i < wcyc.size()) ? wcyc[i] : -100;
  endfunction

  task automatic step();
    @(negedge CLK);
    if (sink_wren) begin
      wlog.push_back(sink_din);
      wcyc.push_back(cyc_n);
    end
    ghist.push_back(grant);
    if (src_rden[0]) rd0_n++;
    if (err_timeout) err_n++;
    cyc_n++;
  endtask

  task automatic clear_logs();
    wlog.delete();
    wcyc.delete();
    ghist.delete();
    cyc_n = 0;
    rd0_n = 0;
    err_n = 0;
  endtask

  task automatic do_reset();
    src_enable       = '0;
    sink_almost_full = 1'b0;
    RESET_N          = 1'b0;
    flush            = '1;
    step();
    step();
    flush   = '0;
    RESET_N = 1'b1;
    clear_logs();
  endtask

  vec_t vecs [8];

  initial begin
    int es, seen, base, stall_bad, err_step;

    vecs[0] = '{en: 4'b1111, load: 4'b0010, exp_grant: 4'b0010};
    vecs[1] = '{en: 4'b1111, load: 4'b0110, exp_grant: 4'b0010};
    vecs[2] = '{en: 4'b1111, load: 4'b1100, exp_grant: 4'b0100};
    vecs[3] = '{en: 4'b1111, load: 4'b1000, exp_grant: 4'b1000};
    vecs[4] = '{en: 4'b1101, load: 4'b0110, exp_grant: 4'b0100};
    vecs[5] = '{en: 4'b0000, load: 4'b1111, exp_grant: 4'b0000};
    vecs[6] = '{en: 4'b1111, load: 4'b1001, exp_grant: 4'b0001};
    vecs[7] = '{en: 4'b1110, load: 4'b1011, exp_grant: 4'b0010};

    RESET_N          = 1'b1;
    src_enable       = '0;
    sink_almost_full = 1'b0;
    flush            = '1;
    clear_logs();
    #1 RESET_N = 1'b0;
    #1;
    chk("reset grant", 64'(grant), 64'h0);
    chk("reset src_rden", 64'(src_rden), 64'h0);
    chk("reset sink_wren", 64'(sink_wren), 64'h0);
    chk("reset err_timeout", 64'(err_timeout), 64'h0);

    // Priority / mask table.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int s = 0; s < 4; s++) if (vecs[v].load[s]) push(s, mk(s, v, 1'b1));
      src_enable = vecs[v].en;
      step();
      chk($sformatf("vec%0d grant", v), 64'(grant), 64'(vecs[v].exp_grant));
      for (int k = 0; k < 10 && wlog.size() == 0; k++) step();
      if (vecs[v].exp_grant == 4'b0000) begin
        chk($sformatf("vec%0d no write", v), 64'(wlog.size()), 64'd0);
      end else begin
        es = 0;
        for (int b = 0; b < 4; b++) if (vecs[v].exp_grant[b]) es = b;
        chk($sformatf("vec%0d word", v), wl(0), mk(es, v, 1'b1));
      end
    end

    // CFG and LOOP together: CFG word in cycle 3, then LOOP.
    do_reset();
    src_enable = 4'b1111;
    push(SrcCfg, mk(SrcCfg, 100, 1'b0));
    push(SrcLoop, mk(SrcLoop, 101, 1'b0));
    repeat (8) step();
    chk("cfgloop grant0", 64'(ghist[0]), 64'h2);
    chk("cfgloop idle gap", 64'(ghist[2]), 64'h0);
    chk("cfgloop grant1", 64'(ghist[3]), 64'h4);
    chk("cfgloop word0", wl(0), mk(SrcCfg, 100, 1'b0));
    chk("cfgloop word0 cycle", 64'(wc(0)), 64'd1);
    chk("cfgloop word1", wl(1), mk(SrcLoop, 101, 1'b0));
    chk("cfgloop word1 cycle", 64'(wc(1)), 64'd4);

    // Four-word TLP packet holds the sink against a waiting CFG word.
    do_reset();
    src_enable = 4'b1111;
    for (int k = 1; k <= 4; k++) push(SrcTlp, mk(SrcTlp, 200 + k, k == 4));
    push(SrcCfg, mk(SrcCfg, 210, 1'b0));
    repeat (12) step();
    chk("tlp grant", 64'(ghist[0]), 64'h1);
    chk("tlp write count", 64'(wlog.size()), 64'd5);
    for (int k = 0; k < 4; k++)
      chk($sformatf("tlp word%0d", k), wl(k), mk(SrcTlp, 201 + k, k == 3));
    chk("tlp contiguous", 64'(wc(3) - wc(0)), 64'd3);
    chk("tlp then cfg", wl(4), mk(SrcCfg, 210, 1'b0));
    chk("tlp rden count", 64'(rd0_n), 64'd4);

    // Starvation: CMD wins the second IDLE despite TLP requesting.
    do_reset();
    src_enable = 4'b1001;
    for (int k = 0; k < 8; k++) push(SrcTlp, mk(SrcTlp, 300 + k, 1'b1));
    push(SrcCmd, mk(SrcCmd, 310, 1'b0));
    seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      step();
      if (grant == 4'b1000) begin
        seen = 1;
        chk("starve tlp still requesting", 64'(src_empty[0]), 64'd0);
        chk("starve tlp packets before cmd", 64'(wlog.size()), 64'd2);
      end
    end
    chk("starve cmd granted", 64'(seen), 64'd1);
    repeat (3) step();
    chk("starve cmd word", wl(2), mk(SrcCmd, 310, 1'b0));

    // Back-pressure after TLP word 2.
    do_reset();
    src_enable = 4'b0011;
    for (int k = 1; k <= 4; k++) push(SrcTlp, mk(SrcTlp, 400 + k, k == 4));
    push(SrcCfg, mk(SrcCfg, 410, 1'b0));
    for (int k = 0; k < 10 && wlog.size() < 2; k++) step();
    sink_almost_full = 1'b1;
    base      = wlog.size();
    stall_bad = 0;
    repeat (10) begin
      step();
      if (grant != 4'b0001) stall_bad++;
    end
    chk("afull lock held", 64'(stall_bad), 64'd0);
    chk("afull at most one write", 64'(wlog.size() - base <= 1), 64'd1);
    sink_almost_full = 1'b0;
    repeat (15) step();
    chk("afull write count", 64'(wlog.size()), 64'd5);
    for (int k = 0; k < 4; k++)
      chk($sformatf("afull word%0d", k), wl(k), mk(SrcTlp, 401 + k, k == 3));
    chk("afull cfg last", wl(4), mk(SrcCfg, 410, 1'b0));
    chk("afull no timeout", 64'(err_n), 64'd0);

    // Lock timeout on an unterminated packet.
    do_reset();
    src_enable = 4'b0001;
    push(SrcTlp, mk(SrcTlp, 500, 1'b0));
    err_step = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (err_timeout && err_step < 0) err_step = k;
    end
    chk("timeout pulse count", 64'(err_n), 64'd1);
    chk("timeout delay window",
        64'((err_step - wc(0) >= 16) && (err_step - wc(0) <= 18)), 64'd1);
    chk("timeout grant", 64'(grant), 64'h0);
    chk("timeout rden", 64'(src_rden), 64'h0);
    chk("timeout single read", 64'(rd0_n), 64'd1);

    // Reset during TLP word 2 with a starved CMD waiting.
    do_reset();
    src_enable       = 4'b1001;
    sink_almost_full = 1'b1;
    for (int k = 1; k <= 4; k++) push(SrcTlp, mk(SrcTlp, 600 + k, k == 4));
    push(SrcCmd, mk(SrcCmd, 610, 1'b0));
    repeat (6) step();
    chk("rst lock before", 64'(grant), 64'h1);
    sink_almost_full = 1'b0;
    for (int k = 0; k < 10 && wlog.size() < 2; k++) step();
    chk("rst reached word2", 64'(wlog.size()), 64'd2);
    RESET_N = 1'b0;
    #1;
    chk("rst mid grant", 64'(grant), 64'h0);
    chk("rst mid rden", 64'(src_rden), 64'h0);
    chk("rst mid wren", 64'(sink_wren), 64'h0);
    chk("rst mid err", 64'(err_timeout), 64'h0);
    flush = 4'b0001;
    step();
    step();
    flush = '0;
    clear_logs();
    push(SrcCfg, mk(SrcCfg, 620, 1'b0));
    src_enable = 4'b1011;
    RESET_N    = 1'b1;
    step();
    chk("rst fresh grant", 64'(grant), 64'h2);
    repeat (10) step();
    chk("rst post count", 64'(wlog.size()), 64'd2);
    chk("rst post cfg", wl(0), mk(SrcCfg, 620, 1'b0));
    chk("rst post cmd", wl(1), mk(SrcCmd, 610, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcileech_tx_arbiter.md
PCILEECH_TX_ARBITER -- requirements
Module: pcileech_tx_arbiter

Interface
REQ-001 SHALL have parameters: STARVE_LIMIT, default 32, meaning consecutive lost-arbitration cycles before a source is promoted; LOCK_TIMEOUT, default 1024, meaning idle cycles allowed inside a locked TLP packet.
REQ-002 SHALL use a single clock CLK, with asynchronous active-low reset RESET_N.
REQ-003 Port: CLK  in  1  sole clock.
REQ-004 Port: RESET_N  in  1  asynchronous, active-low reset.
REQ-005 Port: src_empty  in  4  per-source FIFO empty flag; index 0=TLP, 1=CFG, 2=LOOP, 3=CMD.
REQ-006 Port: src_valid  in  4  per-source FIFO read data valid; asserted exactly one cycle after the matching src_rden.
REQ-007 Port: src_dout  in  256  four 64-bit words, source i at bits [64i+63:64i].
REQ-008 Port: src_rden  out  4  per-source FIFO read enable.
REQ-009 Port: src_enable  in  4  per-source arbitration mask.
REQ-010 Port: sink_almost_full  in  1  back-pressure from the 64->32 FT601 TX FIFO.
REQ-011 Port: sink_din  out  64  word to the FT601 TX FIFO.
REQ-012 Port: sink_wren  out  1  write strobe to the FT601 TX FIFO.
REQ-013 Port: grant  out  4  one-hot current owner; zero when IDLE.
REQ-014 Port: err_timeout  out  1  one-cycle pulse when a locked packet is aborted.

Function
REQ-015 A source is requesting when src_enable[i] & ~src_empty[i].
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN and LOCK.
REQ-017 IDLE: if any source is requesting, the FSM SHALL register winner g and go to LOCK when g=0, or to ISSUE when g is 1-3; otherwise it SHALL stay in IDLE.
REQ-018 Winner selection: the lowest-index starved source wins; when no source is starved, the lowest-index requesting source wins.
REQ-019 Starve counter per source: it SHALL increment, saturating, on every cycle the source is requesting and not granted; it SHALL clear when the source is granted or stops requesting. A source is starved when its counter >= STARVE_LIMIT.
REQ-020 ISSUE (sources 1-3, single-word packets): src_rden[g] = ~src_empty[g] & ~sink_almost_full; the FSM SHALL go to DRAIN in the cycle src_rden[g] is asserted.
REQ-021 DRAIN: the FSM SHALL go to IDLE on src_valid[g].
REQ-022 LOCK (TLP): src_rden[0] = ~src_empty[0] & ~sink_almost_full & ~(src_valid[0] & src_dout[10]), so no word past the packet end is fetched.
REQ-023 LOCK SHALL be left for IDLE in the cycle after src_valid[0] with src_dout[10]=1.
REQ-024 sink_wren = src_valid[g] while grant is nonzero; sink_din SHALL be src_dout of g, combinational, passed through unmodified.
REQ-025 LOCK idle counter: it SHALL count cycles with no src_valid[0] and clear on src_valid[0]. When it reaches LOCK_TIMEOUT, the FSM SHALL go to IDLE and pulse err_timeout for one cycle.
REQ-026 sink_almost_full mid-packet SHALL stall reads while the lock is held; no other source may interleave.
REQ-027 A read already outstanding when sink_almost_full rises SHALL still be written; the sink's headroom absorbs it.
REQ-028 Deassertion of src_enable[g] while granted SHALL NOT abort the grant; the mask applies only in IDLE.
REQ-029 src_rden SHALL be zero for every non-granted source, and in IDLE and DRAIN.

Reset
REQ-030 Asserting RESET_N low SHALL immediately force: state IDLE; grant, src_rden, sink_wren and err_timeout = 0; all counters = 0.
REQ-031 Reset mid-packet SHALL discard any outstanding read; no recovery or replay is attempted.

Structure
REQ-032 A shared package/header pcileech_fifo_pkg SHALL hold: the source index constants, the FSM state encoding, the magic 8'h77, and the TLP last-DWORD bit position (10).
REQ-033 One sub-module, pcileech_starve_ctr, SHALL be instantiated four times: a saturating counter with a starved flag.

Verification
REQ-034 CFG and LOOP requesting together from IDLE, sink free -> CFG word on sink in cycle 3, then LOOP word; grant 0010 then 0100.
REQ-035 TLP packet of 4 words (last flag on word 4) while CFG is requesting -> all 4 TLP words written contiguously before any CFG word; src_rden[0] asserted exactly 4 times.
REQ-036 TLP continuously requesting, CMD requesting, STARVE_LIMIT=4 -> CMD granted at the first IDLE after its counter reaches 4, even though TLP is requesting.
REQ-037 sink_almost_full high for 10 cycles after TLP word 2 -> at most 1 further sink_wren during the stall, lock held, remaining words follow after release.
REQ-038 LOCK with src_empty[0]=1 for LOCK_TIMEOUT=16 cycles -> err_timeout pulses once, state returns to IDLE, grant=0.
REQ-039 RESET_N low during TLP word 2 -> all outputs 0 in the same cycle; after release, the next grant is based only on fresh requests.
